// File: rtl/dly_tap_ctrl.sv
// Tap-walk initiator for an output delay primitive: optional DLY_LOAD, then DLY_ADJ steps until the tap matches.
// Build option DLY_TAP_CTRL_STEP_CNT_EN exposes the per-request adjust-pulse count on STEP_CNT.
module dly_tap_ctrl #(
  parameter int PULSE_WIDTH   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic [5:0] REQ_TAP,
  input  logic       REQ_LOAD,
  output logic       DONE,
  output logic       ERR,
  output logic [5:0] CUR_TAP,
  output logic       DLY_LOAD,
  output logic       DLY_ADJ,
  output logic       DLY_INCDEC,
  input  logic [5:0] DLY_TAP_VALUE,
  output logic [5:0] STEP_CNT
);

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, CMP, ADJ_HI, ADJ_LO, FIN
  } state_t;

  localparam logic [3:0] PULSE_LAST  = 4'(PULSE_WIDTH - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] timer_reg, timer_next;
  logic [5:0] target_reg, target_next;
  logic [5:0] prev_tap_reg, prev_tap_next;
  logic       check_reg, check_next;
  logic       err_reg, err_next;
  logic       done_reg, done_next;
  logic       load_reg, load_next;
  logic       adj_reg, adj_next;
  logic       incdec_reg, incdec_next;
  logic [5:0] adj_cnt_reg, adj_cnt_next;
  logic [5:0] cur_tap_reg;

  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      target_reg   <= '0;
      prev_tap_reg <= '0;
      check_reg    <= 1'b0;
      err_reg      <= 1'b0;
      done_reg     <= 1'b0;
      load_reg     <= 1'b0;
      adj_reg      <= 1'b0;
      incdec_reg   <= 1'b0;
      adj_cnt_reg  <= '0;
      cur_tap_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      target_reg   <= target_next;
      prev_tap_reg <= prev_tap_next;
      check_reg    <= check_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
      load_reg     <= load_next;
      adj_reg      <= adj_next;
      incdec_reg   <= incdec_next;
      adj_cnt_reg  <= adj_cnt_next;
      cur_tap_reg  <= DLY_TAP_VALUE;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    target_next   = target_reg;
    prev_tap_next = prev_tap_reg;
    check_next    = check_reg;
    err_next      = err_reg;
    incdec_next   = incdec_reg;
    adj_cnt_next  = adj_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (REQ_VALID) begin
          target_next  = REQ_TAP;
          err_next     = 1'b0;
          check_next   = 1'b0;
          adj_cnt_next = '0;
          if (REQ_LOAD) begin
            state_next = LOAD_HI;
            timer_next = PULSE_LAST;
          end else begin
            state_next = CMP;
          end
        end
      end
      LOAD_HI: begin
        if (timer_reg == 4'd0) begin
          state_next = LOAD_LO;
          timer_next = SETTLE_LAST;
        end else begin
          timer_next = timer_reg - 4'd1;
        end
      end
      LOAD_LO: begin
        if (timer_reg == 4'd0) state_next = CMP;
        else timer_next = timer_reg - 4'd1;
      end
      CMP: begin
        if (check_reg && (cur_tap_reg == prev_tap_reg)) begin
          err_next   = 1'b1;
          state_next = FIN;
        end else if (cur_tap_reg == target_reg) begin
          state_next = FIN;
        end else if (adj_cnt_reg == 6'd63) begin
          // Runaway guard for a tap that moves but never converges.
          err_next   = 1'b1;
          state_next = FIN;
        end else begin
          incdec_next   = (cur_tap_reg < target_reg);
          prev_tap_next = cur_tap_reg;
          check_next    = 1'b1;
          adj_cnt_next  = adj_cnt_reg + 6'd1;
          timer_next    = PULSE_LAST;
          state_next    = ADJ_HI;
        end
      end
      ADJ_HI: begin
        if (timer_reg == 4'd0) begin
          state_next = ADJ_LO;
          timer_next = SETTLE_LAST;
        end else begin
          timer_next = timer_reg - 4'd1;
        end
      end
      ADJ_LO: begin
        if (timer_reg == 4'd0) state_next = CMP;
        else timer_next = timer_reg - 4'd1;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Strobes are decoded from the next state so they leave a flop aligned with the state.
    done_next = (state_next == FIN);
    load_next = (state_next == LOAD_HI);
    adj_next  = (state_next == ADJ_HI);
  end

  assign REQ_READY  = (state_reg == IDLE);
  assign DONE       = done_reg;
  assign ERR        = err_reg;
  assign CUR_TAP    = cur_tap_reg;
  assign DLY_LOAD   = load_reg;
  assign DLY_ADJ    = adj_reg;
  assign DLY_INCDEC = incdec_reg;

`ifdef DLY_TAP_CTRL_STEP_CNT_EN
  assign STEP_CNT = adj_cnt_reg;
`else
  assign STEP_CNT = 6'd0;
`endif

endmodule

// File: tb/tb_dly_tap_ctrl.sv
// Directed bench for dly_tap_ctrl with a behavioural delay-primitive model (load value 20, one step per ADJ pulse).
module tb_dly_tap_ctrl;

  logic       CLK_IN = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [5:0] REQ_TAP;
  logic       REQ_LOAD;
  logic       DONE;
  logic       ERR;
  logic [5:0] CUR_TAP;
  logic       DLY_LOAD;
  logic       DLY_ADJ;
  logic       DLY_INCDEC;
  logic [5:0] DLY_TAP_VALUE;
  logic [5:0] STEP_CNT;

  int total = 0;
  int bad   = 0;

  logic [5:0] prim_tap  = 6'd0;
  logic       prim_prev = 1'b0;
  logic       stuck     = 1'b0;
  logic [5:0] stuck_val = 6'd0;

`ifdef DLY_TAP_CTRL_STEP_CNT_EN
  localparam int STEP18 = 18;
`else
  localparam int STEP18 = 0;
`endif

  dly_tap_ctrl dut (
    .CLK_IN(CLK_IN), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_TAP(REQ_TAP), .REQ_LOAD(REQ_LOAD), .DONE(DONE), .ERR(ERR),
    .CUR_TAP(CUR_TAP), .DLY_LOAD(DLY_LOAD), .DLY_ADJ(DLY_ADJ),
    .DLY_INCDEC(DLY_INCDEC), .DLY_TAP_VALUE(DLY_TAP_VALUE), .STEP_CNT(STEP_CNT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Primitive model: load forces 20, each rising DLY_ADJ moves one tap.
  always @(posedge CLK_IN) begin
    prim_prev <= DLY_ADJ;
    if (stuck)                     prim_tap <= stuck_val;
    else if (DLY_LOAD)             prim_tap <= 6'd20;
    else if (DLY_ADJ && !prim_prev) prim_tap <= DLY_INCDEC ? prim_tap + 6'd1 : prim_tap - 6'd1;
  end
  assign DLY_TAP_VALUE = prim_tap;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [5:0] tap, input logic load);
    @(negedge CLK_IN);
    REQ_VALID = 1'b1;
    REQ_TAP   = tap;
    REQ_LOAD  = load;
    @(posedge CLK_IN);
  endtask

  // Runs from just after the accept edge until DONE; cycle 1 is the first cycle after accept.
  task automatic wait_done(input logic keep_valid, input logic [5:0] next_tap,
                           output int cyc, output int adj_p, output int inc_p,
                           output int load_hi, output int ready_hi, output int err_c1);
    logic prev_adj;
    logic got;
    prev_adj = 1'b0;
    got = 1'b0;
    cyc = 0; adj_p = 0; inc_p = 0; load_hi = 0; ready_hi = 0; err_c1 = 0;
    while (!got && cyc < 400) begin
      @(negedge CLK_IN);
      cyc++;
      if (cyc == 1) begin
        REQ_VALID = keep_valid;
        REQ_TAP   = next_tap;
        err_c1    = int'(ERR);
      end
      if (DLY_ADJ && !prev_adj) begin
        adj_p++;
        if (DLY_INCDEC) inc_p++;
      end
      prev_adj = DLY_ADJ;
      load_hi += int'(DLY_LOAD);
      ready_hi += int'(REQ_READY);
      if (DONE) got = 1'b1;
    end
    check("done_seen", int'(got), 1);
  endtask

  int cyc, adj_p, inc_p, load_hi, ready_hi, err_c1, cnt;

  initial begin
    RST = 1'b0;
    REQ_VALID = 1'b0; REQ_TAP = 6'd0; REQ_LOAD = 1'b0;

    // 1: reset with random inputs
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_IN);
      REQ_VALID = 1'($urandom); REQ_TAP = 6'($urandom); REQ_LOAD = 1'($urandom);
      stuck_val = 6'($urandom);
      #1;
      check("rst_load", int'(DLY_LOAD), 0);
      check("rst_adj", int'(DLY_ADJ), 0);
      check("rst_incdec", int'(DLY_INCDEC), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_err", int'(ERR), 0);
      check("rst_cur_tap", int'(CUR_TAP), 0);
      check("rst_step_cnt", int'(STEP_CNT), 0);
      check("rst_ready", int'(REQ_READY), 1);
    end
    @(negedge CLK_IN);
    RST = 1'b1; REQ_VALID = 1'b0; stuck = 1'b0;
    @(negedge CLK_IN);
    check("post_rst_ready", int'(REQ_READY), 1);

    // 2: load then increment to 23
    issue(6'd23, 1'b1);
    wait_done(1'b0, 6'd23, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn load->23: done_cycle=%0d adj=%0d inc=%0d load_hi=%0d cur=%0d err=%0d", cyc, adj_p, inc_p, load_hi, CUR_TAP, ERR);
    check("t2_cycle", cyc, 29);
    check("t2_load_hi", load_hi, 2);
    check("t2_adj", adj_p, 3);
    check("t2_inc", inc_p, 3);
    check("t2_cur", int'(CUR_TAP), 23);
    check("t2_err", int'(ERR), 0);

    // 3: decrement to 5, then same target again
    issue(6'd5, 1'b0);
    wait_done(1'b0, 6'd5, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn 23->5: done_cycle=%0d adj=%0d inc=%0d cur=%0d step_cnt=%0d", cyc, adj_p, inc_p, CUR_TAP, STEP_CNT);
    check("t3_cycle", cyc, 128);
    check("t3_adj", adj_p, 18);
    check("t3_inc", inc_p, 0);
    check("t3_load_hi", load_hi, 0);
    check("t3_cur", int'(CUR_TAP), 5);
    check("t3_err", int'(ERR), 0);
    check("t3_step_cnt", int'(STEP_CNT), STEP18);
    repeat (4) @(negedge CLK_IN);
    check("t3_step_hold", int'(STEP_CNT), STEP18);
    check("t3_incdec_hold", int'(DLY_INCDEC), 0);
    issue(6'd5, 1'b0);
    wait_done(1'b0, 6'd5, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn 5->5: done_cycle=%0d adj=%0d", cyc, adj_p);
    check("t3b_cycle", cyc, 2);
    check("t3b_adj", adj_p, 0);
    check("t3b_step_cnt", int'(STEP_CNT), 0);

    // 4: stuck tap
    @(negedge CLK_IN);
    stuck = 1'b1; stuck_val = 6'd10;
    repeat (3) @(negedge CLK_IN);
    issue(6'd12, 1'b0);
    wait_done(1'b0, 6'd12, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn stuck 10->12: done_cycle=%0d adj=%0d err=%0d", cyc, adj_p, ERR);
    check("t4_cycle", cyc, 9);
    check("t4_adj", adj_p, 1);
    check("t4_inc", inc_p, 1);
    check("t4_err", int'(ERR), 1);
    repeat (3) @(negedge CLK_IN);
    check("t4_err_hold", int'(ERR), 1);
    stuck = 1'b0;
    issue(6'd10, 1'b0);
    wait_done(1'b0, 6'd10, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn 10->10 after err: done_cycle=%0d err_c1=%0d err=%0d", cyc, err_c1, ERR);
    check("t4b_err_clear", err_c1, 0);
    check("t4b_cycle", cyc, 2);
    check("t4b_err", int'(ERR), 0);

    // 5a: busy - REQ_VALID held through a walk
    issue(6'd15, 1'b0);
    wait_done(1'b1, 6'd12, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn busy 10->15: done_cycle=%0d adj=%0d ready_hi=%0d", cyc, adj_p, ready_hi);
    check("t5_cycle", cyc, 37);
    check("t5_adj", adj_p, 5);
    check("t5_ready_busy", ready_hi, 0);
    @(negedge CLK_IN);
    check("t5_ready_after", int'(REQ_READY), 1);
    @(posedge CLK_IN);
    wait_done(1'b0, 6'd12, cyc, adj_p, inc_p, load_hi, ready_hi, err_c1);
    $display("txn queued 15->12: done_cycle=%0d adj=%0d cur=%0d", cyc, adj_p, CUR_TAP);
    check("t5b_cycle", cyc, 23);
    check("t5b_adj", adj_p, 3);
    check("t5b_cur", int'(CUR_TAP), 12);

    // 5b: reset abort mid-walk
    issue(6'd40, 1'b0);
    @(negedge CLK_IN);
    REQ_VALID = 1'b0;
    repeat (9) @(negedge CLK_IN);
    check("t5c_adj_before", int'(DLY_ADJ), 1);
    #1 RST = 1'b0;
    #1;
    $display("txn abort: adj=%0d ready=%0d done=%0d", DLY_ADJ, REQ_READY, DONE);
    check("t5c_adj_abort", int'(DLY_ADJ), 0);
    check("t5c_ready_abort", int'(REQ_READY), 1);
    check("t5c_done_abort", int'(DONE), 0);
    @(negedge CLK_IN);
    RST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_IN);
      cnt += int'(DONE) + int'(!REQ_READY);
    end
    check("t5c_quiet", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dly_tap_ctrl.md
Name: dly_tap_ctrl

Overview:
Control-side initiator for the output delay primitive's tap interface. It accepts a target tap value over a valid/ready request port and optionally issues a tap load first. It then walks the primitive's tap with DLY_ADJ/DLY_INCDEC pulses until the returned DLY_TAP_VALUE equals the target. It sits in the I/O calibration logic next to each delay primitive and flags taps that fail to move.

Parameters:
PULSE_WIDTH, 2, cycles DLY_LOAD/DLY_ADJ held high per pulse (legal 1-15)
SETTLE_CYCLES, 4, cycles the pulse is held low before the tap is re-checked (legal 2-15; PULSE_WIDTH+SETTLE_CYCLES >= 4)

Ports:
CLK_IN  input  1  clock, shared with the delay primitive
RST  input  1  reset, asynchronous, active-low
REQ_VALID  input  1  request valid
REQ_READY  output  1  request ready; high only in IDLE
REQ_TAP  input  6  target tap value 0-63
REQ_LOAD  input  1  1 = pulse DLY_LOAD before walking
DONE  output  1  one-cycle completion pulse
ERR  output  1  tap failed to move; valid with DONE; held until next accept
CUR_TAP  output  6  DLY_TAP_VALUE registered every cycle
DLY_LOAD  output  1  to primitive
DLY_ADJ  output  1  to primitive
DLY_INCDEC  output  1  to primitive; 1 = increment
DLY_TAP_VALUE  input  6  from primitive
STEP_CNT  output  6  adjust pulses issued for current/last request (see Optional Feature)

Behaviour:
- Reset (RST=0, async):
  - State goes to IDLE.
  - DLY_LOAD, DLY_ADJ, DLY_INCDEC, DONE and ERR are 0; CUR_TAP and STEP_CNT are 0; REQ_READY is 1.
  - Reset mid-operation aborts immediately, the in-flight request is lost and no DONE is issued.
- States: IDLE, LOAD_HI, LOAD_LO, CMP, ADJ_HI, ADJ_LO, FIN. All outputs are registered except REQ_READY = (state==IDLE).
- IDLE:
  - A request is accepted when REQ_VALID && REQ_READY at a clock edge (cycle 0).
  - On accept: latch REQ_TAP and REQ_LOAD, clear ERR, clear the moved-check flag.
  - Next state is LOAD_HI if REQ_LOAD, else CMP.
  - REQ_VALID while not IDLE is ignored.
- LOAD_HI: DLY_LOAD=1 for PULSE_WIDTH cycles, then LOAD_LO.
- LOAD_LO: DLY_LOAD=0 for SETTLE_CYCLES cycles, then CMP.
- CMP (1 cycle):
  - If the check flag is set and CUR_TAP == tap recorded before the last step: ERR=1, go to FIN.
  - Else if CUR_TAP == target: go to FIN.
  - Else: DLY_INCDEC = (CUR_TAP < target), record CUR_TAP, set the check flag, go to ADJ_HI.
- ADJ_HI: DLY_ADJ=1 for PULSE_WIDTH cycles, then ADJ_LO.
- ADJ_LO: DLY_ADJ=0 for SETTLE_CYCLES cycles, then CMP.
- DLY_INCDEC is stable from CMP through ADJ_LO and holds its last value in IDLE.
- FIN: DONE=1 for exactly one cycle, then IDLE; REQ_READY returns the same cycle IDLE is entered.
- Latency: DONE is high in cycle 1 + L·(PULSE_WIDTH+SETTLE_CYCLES) + N·(PULSE_WIDTH+SETTLE_CYCLES+1) + 1, where L = REQ_LOAD and N = steps taken.
  - Defaults: each step costs 7 cycles; a no-load request already on target gives DONE in cycle 2.
- Boundaries:
  - A target of 0 or 63 is reached normally.
  - A tap that is stuck or clamped gives ERR on the first non-moving step; the block never loops forever.
  - The block never issues more than 63 adjust pulses per request.

Optional Feature:
Macro DLY_TAP_CTRL_STEP_CNT_EN.
- Defined:
  - STEP_CNT clears on accept and increments on each entry to ADJ_HI.
  - It holds after DONE until the next accept.
  - Maximum value is 63 with no wrap.
- Undefined: the counter is not built and STEP_CNT is tied to 0.

Test Plan:
1. Reset: hold RST=0 with random inputs -> DLY_LOAD=DLY_ADJ=DLY_INCDEC=0, DONE=ERR=0, CUR_TAP=0, REQ_READY=1; release -> REQ_READY stays 1.
2. Load then increment (primitive DELAY=20, defaults): REQ_LOAD=1, REQ_TAP=23 -> one 2-cycle DLY_LOAD pulse, 3 increment ADJ pulses with DLY_INCDEC=1, DONE in cycle 29, CUR_TAP=23, ERR=0.
3. Decrement: from tap 23, REQ_LOAD=0, REQ_TAP=5 -> 18 ADJ pulses with DLY_INCDEC=0, DONE in cycle 128, CUR_TAP=5; same target again -> DONE in cycle 2, no pulses.
4. Stuck tap: DLY_TAP_VALUE forced to 10, REQ_TAP=12 -> exactly one ADJ pulse, DONE and ERR=1 in cycle 9; ERR clears on the next accept.
5. Busy and reset abort: REQ_VALID held high during a walk -> REQ_READY=0 throughout, second request accepted the cycle after DONE. RST=0 at cycle 10 of a walk -> DLY_ADJ=0 immediately, no DONE, REQ_READY=1.
6. With DLY_TAP_CTRL_STEP_CNT_EN: after scenario 3's walk STEP_CNT=18 and holds. Without the macro: STEP_CNT=0 always.
